// File: rtl/serial_mod_arbiter_ctrl.sv
// serial_mod_arbiter_ctrl: two-requester round-robin front end for a bit-serial mod-DIV engine
//
// Ports:
//   clk                     rising-edge clock
//   rst                     asynchronous active-low reset
//   req0_valid/data/ready   requester 0 operand handshake (W bits)
//   req1_valid/data/ready   requester 1 operand handshake (W bits)
//   res_valid/res_ready     result handshake; res_valid is high while in DONE
//   res_div                 operand mod DIV == 0
//   res_rem                 operand mod DIV (RW bits)
//   res_id                  requester that supplied the operand
//   busy                    controller not idle
//
// Build option SERIAL_MOD_ARB_ZERO_FAST_EN: a zero operand bypasses the W
// shift cycles and reaches DONE one cycle after its handshake.
// RW is derived from DIV and must not be overridden.
module serial_mod_arbiter_ctrl #(
    parameter int W   = 16,
    parameter int DIV = 5,
    parameter int RW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_data,
    output logic          req1_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_div,
    output logic [RW-1:0] res_rem,
    output logic          res_id,
    output logic          busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam int CW = $clog2(W + 1);
    localparam logic [RW:0] DIV_V = (RW + 1)'(DIV);
    localparam logic [CW-1:0] LAST = CW'(W);

    logic [1:0]    state;
    logic          last_served;
    logic [W-1:0]  sreg;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rem;
    logic          g0, g1, take, zero_fast;
    logic [W-1:0]  din;
    logic [RW:0]   t;
    logic [RW-1:0] rem_n;

    // on a tie the requester served less recently wins
    assign g0 = req0_valid && (!req1_valid || last_served);
    assign g1 = req1_valid && (!req0_valid || !last_served);
    assign req0_ready = (state == IDLE) && g0;
    assign req1_ready = (state == IDLE) && g1;
    assign take = req0_ready || req1_ready;
    assign din = req1_ready ? req1_data : req0_data;
    assign res_valid = (state == DONE);
    assign busy = (state != IDLE);

    // 2*rem+msb < 2*DIV, so one conditional subtract reduces it
    assign t = {rem, sreg[W-1]};
    assign rem_n = (t >= DIV_V) ? RW'(t - DIV_V) : t[RW-1:0];

`ifdef SERIAL_MOD_ARB_ZERO_FAST_EN
    assign zero_fast = (din == '0);
`else
    assign zero_fast = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            sreg        <= '0;
            cnt         <= '0;
            rem         <= '0;
            res_div     <= 1'b0;
            res_rem     <= '0;
            res_id      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    sreg        <= din;
                    rem         <= '0;
                    // a zero operand with the fast path starts at the terminal count
                    cnt         <= zero_fast ? LAST : '0;
                    res_id      <= req1_ready;
                    last_served <= req1_ready;
                    state       <= SHIFT;
                end
                SHIFT: if (cnt == LAST) begin
                    res_rem <= rem;
                    res_div <= (rem == '0);
                    state   <= DONE;
                end else begin
                    rem  <= rem_n;
                    sreg <= {sreg[W-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                end
                DONE: if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_mod_arbiter_ctrl.sv
// tb_serial_mod_arbiter_ctrl: vector table, corner sequences and random traffic against a reference model
module tb_serial_mod_arbiter_ctrl;
    localparam int W   = 16;
    localparam int DIV = 5;
    localparam int RW  = $clog2(DIV);
`ifdef SERIAL_MOD_ARB_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
    logic [W-1:0]  req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready, res_valid, res_div, res_id, busy;
    logic [RW-1:0] res_rem;

    always #5 clk = ~clk;

    serial_mod_arbiter_ctrl #(.W(W), .DIV(DIV)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_div(res_div),
        .res_rem(res_rem), .res_id(res_id), .busy(busy)
    );

    typedef struct {
        logic         v0, v1;
        logic [W-1:0] d0, d1;
        logic         eid;
        logic [2:0]   erem;
        logic         ediv;
    } vec_t;

    vec_t tbl[10];
    int   n_vec = 0, n_err = 0;
    logic m_last = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_grant(input logic v0, input logic v1, input logic last);
        return (v0 && v1) ? !last : v1;
    endfunction

    function automatic int m_lat(input logic [W-1:0] d);
        return (FAST && d == '0) ? 1 : W + 1;
    endfunction

    task automatic accept(input logic v0, input logic v1, input logic [W-1:0] d0,
                          input logic [W-1:0] d1, output logic id, output logic [W-1:0] d);
        int n = 0;
        req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
        #1;
        while (!(req0_ready || req1_ready) && n < 60) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_timeout", n < 60, 1);
        id = m_grant(v0, v1, m_last);
        d  = id ? d1 : d0;
        chk("ready0", req0_ready, !id);
        chk("ready1", req1_ready, id);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = W'($urandom); req1_data = W'($urandom);
        m_last = id;
    endtask

    task automatic result(input logic eid, input logic [31:0] erem, input logic ediv, input int elat);
        int lat = 0;
        while (!res_valid && lat < 100) begin
            chk("busy", busy, 1);
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, elat);
        chk("res_id", res_id, eid);
        chk("res_rem", res_rem, erem);
        chk("res_div", res_div, ediv);
    endtask

    task automatic release_res(input int dly);
        repeat (dly) begin @(posedge clk); #1; end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
    endtask

    initial begin
        logic         id;
        logic [W-1:0] d;
        logic         saw;
        tbl[0] = '{1'b1, 1'b1, 16'd10,    16'd11,    1'b0, 3'd0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 16'd10,    16'd11,    1'b1, 3'd1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 16'd10,    16'd11,    1'b0, 3'd0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 16'h000F,  16'h0000,  1'b0, 3'd0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 16'h0007,  16'h0000,  1'b0, 3'd2, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 16'h0000,  16'hFFFF,  1'b1, 3'd0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 16'h1235,  16'h0000,  1'b0, 3'd1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 16'h0000,  16'hFFFE,  1'b1, 3'd4, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 16'd3,     16'd8,     1'b0, 3'd3, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 16'd3,     16'd8,     1'b1, 3'd3, 1'b0};

        #2 rst = 1'b0;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_rem", res_rem, 0);
        chk("rst_res_div", res_div, 0);
        chk("rst_res_id", res_id, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            accept(tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1, id, d);
            result(tbl[i].eid, 32'(tbl[i].erem), tbl[i].ediv, W + 1);
            release_res(0);
        end

        // result held while the consumer stalls; data wiggles while not ready
        accept(1'b1, 1'b0, 16'h0007, 16'h0, id, d);
        result(id, 2, 0, W + 1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_data = W'($urandom); req1_data = W'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_rem", res_rem, 2);
            chk("hold_div", res_div, 0);
            chk("hold_id", res_id, id);
            chk("hold_ready0", req0_ready, 0);
            chk("hold_ready1", req1_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("bubble_valid", res_valid, 0);
        chk("bubble_busy", busy, 0);
        chk("bubble_ready1", req1_ready, m_grant(1'b1, 1'b1, m_last));
        accept(1'b1, 1'b1, 16'd24, 16'd26, id, d);
        result(id, 32'(d % DIV), (d % DIV) == 0, W + 1);
        release_res(1);

        // reset in the middle of a shift drops the pending result
        accept(1'b0, 1'b1, 16'h0, 16'h0123, id, d);
        repeat (8) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rem", res_rem, 0);
        chk("mid_rst_div", res_div, 0);
        chk("mid_rst_id", res_id, 0);
        #2 rst = 1'b1;
        m_last = 1'b1;
        saw = 1'b0;
        repeat (25) begin @(posedge clk); #1; saw |= res_valid; end
        chk("no_result_after_rst", saw, 0);
        res_ready = 1'b1;
        accept(1'b0, 1'b1, 16'h0, 16'd3, id, d);
        result(1'b1, 3, 0, W + 1);
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("early_ready_taken", res_valid, 0);
        accept(1'b1, 1'b1, 16'd10, 16'd11, id, d);
        chk("tie_after_rst", id, 0);
        result(1'b0, 0, 1, W + 1);
        release_res(0);

        // zero operand
        accept(1'b1, 1'b0, 16'h0, 16'h0, id, d);
        result(1'b0, 0, 1, FAST ? 1 : W + 1);
        release_res(0);

        for (int i = 0; i < 40; i++) begin
            logic v0, v1;
            logic [W-1:0] d0, d1;
            v0 = 1'($urandom); v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            d0 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            d1 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            accept(v0, v1, d0, d1, id, d);
            result(id, 32'(d % DIV), (d % DIV) == 0, m_lat(d));
            release_res($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
